// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour-field layout and frame-buffer address format.
// Used by both the frame reader and the frame-buffer writer.
package vga_pkg;

  localparam int unsigned DEF_H_VIS   = 640;
  localparam int unsigned DEF_H_FP    = 16;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_H_TOTAL = 800;

  localparam int unsigned DEF_V_VIS   = 480;
  localparam int unsigned DEF_V_FP    = 10;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 33;
  localparam int unsigned DEF_V_TOTAL = 525;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned ROW_W    = 7;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned COLOUR_W = 8;
  localparam int unsigned FG_LSB   = 8;
  localparam int unsigned BG_LSB   = 0;

  // Buffer word for a 160x120 image cell; row/col are the 4x-decimated counters.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider, H/V raster counters and visible/sync/frame-start decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = DEF_H_VIS,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned V_VIS   = DEF_V_VIS,
  parameter int unsigned V_FP    = DEF_V_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             pix_en,
  output logic             visible,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             frame_start,
  output logic [ROW_W-1:0] pix_row,
  output logic [COL_W-1:0] pix_col
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_wrap, v_wrap;

  always_comb begin
    pix_en = (div_q == DIV_W'(CLK_DIV - 1));
    h_wrap = (h_q == CNT_W'(H_TOTAL - 1));
    v_wrap = (v_q == CNT_W'(V_TOTAL - 1));
    div_d  = pix_en ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  always_comb begin
    visible = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
    hsync_n = !((h_q >= CNT_W'(H_VIS + H_FP)) && (h_q < CNT_W'(H_VIS + H_FP + H_SYNC)));
    vsync_n = !((v_q >= CNT_W'(V_VIS + V_FP)) && (v_q < CNT_W'(V_VIS + V_FP + V_SYNC)));
    // Asserted on the tick that moves the raster from the last visible line into blanking.
    frame_start = pix_en && h_wrap && (v_q == CNT_W'(V_VIS - 1));
    pix_row = v_q[8:2];
    pix_col = h_q[9:2];
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Reads a 160x120 1-bit frame buffer and drives a 4x-scaled VGA raster with two latched colours.
// Optional VGA_TEST_PATTERN_EN adds TEST_MODE, replacing buffer data with a 32-pixel checkerboard.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = DEF_H_VIS,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned V_VIS   = DEF_V_VIS,
  parameter int unsigned V_FP    = DEF_V_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP
) (
  input  logic                CLK,
  input  logic                RESET,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                TEST_MODE,
`endif
  input  logic [15:0]         CONFIG_COLOURS,
  output logic [ADDR_W-1:0]   VGA_ADDR,
  input  logic                VGA_DATA,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic [COLOUR_W-1:0] VGA_COLOUR,
  output logic                FRAME_START
);

  logic             pix_en;
  logic             visible;
  logic             hsync_n;
  logic             vsync_n;
  logic             frame_start;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;
  logic             pix_bit;

  logic [ADDR_W-1:0]   addr_q;
  logic                hs_q;
  logic                vs_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [COLOUR_W-1:0] fg_q;
  logic [COLOUR_W-1:0] bg_q;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .CLK         (CLK),
    .RESET       (RESET),
    .pix_en      (pix_en),
    .visible     (visible),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_start (frame_start),
    .pix_row     (pix_row),
    .pix_col     (pix_col)
  );

`ifdef VGA_TEST_PATTERN_EN
  // pix_col[3] is H[5] and pix_row[3] is V[5].
  assign pix_bit = TEST_MODE ? (pix_col[3] ^ pix_row[3]) : VGA_DATA;
`else
  assign pix_bit = VGA_DATA;
`endif

  // Sync and colour are captured together on the pixel tick so they leave with equal latency.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q   <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      colour_q <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
    end else begin
      addr_q <= visible ? pix_addr(pix_row, pix_col) : '0;
      if (frame_start) begin
        fg_q <= CONFIG_COLOURS[FG_LSB +: COLOUR_W];
        bg_q <= CONFIG_COLOURS[BG_LSB +: COLOUR_W];
      end
      if (pix_en) begin
        hs_q     <= hsync_n;
        vs_q     <= vsync_n;
        colour_q <= !visible ? '0 : (pix_bit ? fg_q : bg_q);
      end
    end
  end

  assign VGA_ADDR    = addr_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_COLOUR  = colour_q;
  assign FRAME_START = frame_start;

endmodule
